eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

RMII transmit framer. It turns a dibit frame stream from the packet builder into a complete on-wire Ethernet frame: preamble/SFD, payload, zero padding to minimum length, FCS, then interframe gap. It owns and sequences a 2-bit-per-cycle CRC-32 engine (poly 0x04C11DB7, init 0xFFFFFFFF, output inverted, input bit 0 shifted first). The framer drives the PHY's TXEN/TXD[1:0] directly at one dibit per `clk`.

## Interface
Parameters:
- `MIN_DIBITS`, default 240: minimum dibits between SFD and FCS (60 bytes). 0 disables padding.
- `IFG_DIBITS`, default 48: idle dibits after FCS (96 bit times).

Ports:
- `clk`  in  1: RMII reference clock; one dibit per cycle.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: upstream dibit valid.
- `in_data`  in  2: payload dibit; bit 0 is first on the wire.
- `in_last`  in  1: marks the final payload dibit; qualified by `in_valid`.
- `in_ready`  out  1: framer accepts `in_data` this cycle.
- `txen`  out  1: RMII TXEN, registered.
- `txd`  out  2: RMII TXD, registered.
- `busy`  out  1: high in any state other than IDLE.
- `underrun`  out  1: one-cycle pulse when `in_valid` drops mid-payload.

## Operation
States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DRAIN.

- **IDLE**
  - `in_ready`=0 and the CRC is held at 0xFFFFFFFF.
  - `in_valid`=1 moves to PREAMBLE.
- **PREAMBLE**
  - 32 cycles: 31 dibits of 2'b01, then one dibit of 2'b11 (SFD).
  - Then moves to DATA.
- **DATA**
  - `in_ready`=1. Each accepted dibit goes to `txd`, feeds the CRC, and increments the saturating dibit count.
  - Accepted with `in_last`:
    - count+1 < `MIN_DIBITS` → PAD.
    - otherwise → FCS.
  - `in_valid`=0 in DATA:
    - pulse `underrun` and drive `txen`=0 from the next cycle; no FCS is sent.
    - the `in_valid`=0 cycle itself emits nothing.
    - go to DRAIN.
- **PAD**
  - Emits 2'b00 dibits, each fed to the CRC, until the count reaches `MIN_DIBITS`.
  - Then moves to FCS.
- **FCS**
  - On entry, latch the 32-bit CRC output F (already inverted).
  - Emit 16 dibits. Dibit k (k=0..15): `txd[0]`=F[31-2k], `txd[1]`=F[30-2k].
  - Then moves to IFG.
- **IFG**
  - `txen`=0 for `IFG_DIBITS` cycles, with `in_ready`=0.
  - Then moves to IDLE. A waiting `in_valid` starts the next frame on the following cycle.
- **DRAIN**
  - `in_ready`=1; accepted dibits are discarded.
  - When `in_last` is accepted → IFG.

Rules:
- `in_ready` is high only in DATA and DRAIN. It is a registered/state-decoded output with no combinational path from `in_valid`.
- Counters: preamble 5 bits, FCS 4 bits, IFG sized to `IFG_DIBITS`, payload count saturating at `MIN_DIBITS`. No maximum frame length is enforced.
- `txen`=1 exactly during the PREAMBLE, DATA, PAD and FCS output cycles. Otherwise `txen`=0 and `txd`=2'b00.

## Timing
- Reset values: `txen`=0, `txd`=2'b00, `in_ready`=0, `busy`=0, `underrun`=0; state IDLE; CRC 0xFFFFFFFF.
- Reset asserted mid-frame: outputs return to reset values at the next edge. No FCS and no IFG are sent.
- `in_valid` first seen high in IDLE at cycle t:
  - first preamble dibit appears on `txd` at t+1;
  - SFD appears at t+32;
  - `in_ready` is high from t+32;
  - the first payload dibit is accepted at t+32 and appears on `txd` at t+33.
- Dibit latency from handshake (`in_valid` & `in_ready`) to `txd` is 1 cycle.
- `txen` is contiguous from the first preamble dibit through the last FCS dibit; there are no gaps.
- The FCS covers payload plus pad only, never preamble or SFD. The first FCS dibit directly follows the last payload or pad dibit.
- With payload length ≥ `MIN_DIBITS` = N dibits, frame duration from the first `txen` cycle is 32+N+16 cycles, followed by `IFG_DIBITS` idle cycles.

## Test plan
- **Check value:** `MIN_DIBITS`=0; payload ASCII "123456789" (36 dibits, LSB first per byte).
  - Expect 31×01, then 11, then the payload unchanged.
  - Then FCS bytes 0x26 0x39 0xF4 0xCB, LSB first.
  - `txen` high for exactly 84 cycles.
- **Padding:** default parameters; 14-byte payload (56 dibits).
  - Expect 184 dibits of 00, then an FCS equal to IEEE CRC-32 of the 60-byte zero-padded frame.
  - `txen` high for 32+240+16 = 288 cycles.
- **Back-to-back:** two frames with `in_valid` held high.
  - Expect `txen` low for exactly 48 cycles between them.
  - The second preamble starts on the cycle after IFG ends.
- **Underrun:** drop `in_valid` for 1 cycle after 10 payload dibits.
  - Expect an `underrun` pulse and `txen` low with no FCS dibits.
  - Remaining dibits through `in_last` are consumed, then 48 idle cycles, then IDLE.
- **Reset:** assert `rst` during the FCS phase.
  - Expect `txen`=0 and `txd`=00 next cycle, with `busy`=0.
  - The next frame's FCS is correct, proving the CRC was re-initialised.

Source files
------------

// File: rtl/eth_tx_framer.sv
// RMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, IFG; one dibit per clk.
// Registered TXEN/TXD (1-cycle handshake-to-wire); in_ready is decoded from state only.
module eth_tx_framer #(
    parameter int MIN_DIBITS = 240,
    parameter int IFG_DIBITS = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       txen,
    output logic [1:0] txd,
    output logic       busy,
    output logic       underrun
);
    localparam int CW = (MIN_DIBITS > 0) ? $clog2(MIN_DIBITS + 1) : 1;
    localparam int IW = (IFG_DIBITS > 1) ? $clog2(IFG_DIBITS) : 1;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG, DRAIN} state_t;

    state_t        state, state_nx;
    logic [4:0]    pre_cnt, pre_cnt_nx;
    logic [3:0]    fcs_cnt, fcs_cnt_nx;
    logic [IW-1:0] ifg_cnt, ifg_cnt_nx;
    logic [CW-1:0] len_cnt, len_cnt_nx;
    logic [31:0]   crc, crc_nx;
    logic          txen_nx, underrun_nx;
    logic [1:0]    txd_nx;

    // MSB-first register fed LSB-first data; the register's top bit is the first FCS bit out.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = (c[31] ^ d[0]) ? ({c[30:0], 1'b0} ^ POLY) : {c[30:0], 1'b0};
        r = (r[31] ^ d[1]) ? ({r[30:0], 1'b0} ^ POLY) : {r[30:0], 1'b0};
        return r;
    endfunction

    assign in_ready = (state == DATA) || (state == DRAIN);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx    = state;
        pre_cnt_nx  = pre_cnt;
        fcs_cnt_nx  = fcs_cnt;
        ifg_cnt_nx  = ifg_cnt;
        len_cnt_nx  = len_cnt;
        crc_nx      = crc;
        txen_nx     = 1'b0;
        txd_nx      = 2'b00;
        underrun_nx = 1'b0;
        case (state)
            IDLE: begin
                crc_nx     = 32'hFFFF_FFFF;
                len_cnt_nx = '0;
                if (in_valid) begin
                    state_nx   = PREAMBLE;
                    pre_cnt_nx = 5'd1;
                    txen_nx    = 1'b1;
                    txd_nx     = 2'b01;
                end
            end
            PREAMBLE: begin
                txen_nx    = 1'b1;
                txd_nx     = (pre_cnt == 5'd31) ? 2'b11 : 2'b01;
                pre_cnt_nx = pre_cnt + 1'b1;
                if (pre_cnt == 5'd31) state_nx = DATA;
            end
            DATA: begin
                if (in_valid) begin
                    txen_nx = 1'b1;
                    txd_nx  = in_data;
                    crc_nx  = crc_dibit(crc, in_data);
                    if (int'(len_cnt) < MIN_DIBITS) len_cnt_nx = len_cnt + 1'b1;
                    if (in_last) begin
                        fcs_cnt_nx = '0;
                        state_nx   = (int'(len_cnt) + 1 < MIN_DIBITS) ? PAD : FCS;
                    end
                end else begin
                    // Starved mid-frame: abandon the frame and swallow the rest of it.
                    underrun_nx = 1'b1;
                    state_nx    = DRAIN;
                end
            end
            PAD: begin
                txen_nx    = 1'b1;
                crc_nx     = crc_dibit(crc, 2'b00);
                len_cnt_nx = len_cnt + 1'b1;
                if (int'(len_cnt) + 1 >= MIN_DIBITS) begin
                    fcs_cnt_nx = '0;
                    state_nx   = FCS;
                end
            end
            FCS: begin
                txen_nx    = 1'b1;
                txd_nx     = {~crc[30], ~crc[31]};
                crc_nx     = {crc[29:0], 2'b00};
                fcs_cnt_nx = fcs_cnt + 1'b1;
                if (fcs_cnt == 4'd15) begin
                    ifg_cnt_nx = '0;
                    state_nx   = IFG;
                end
            end
            IFG: begin
                ifg_cnt_nx = ifg_cnt + 1'b1;
                if (int'(ifg_cnt) >= IFG_DIBITS - 1) state_nx = IDLE;
            end
            DRAIN: begin
                if (in_valid && in_last) begin
                    ifg_cnt_nx = '0;
                    state_nx   = IFG;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            fcs_cnt  <= '0;
            ifg_cnt  <= '0;
            len_cnt  <= '0;
            crc      <= 32'hFFFF_FFFF;
            txen     <= 1'b0;
            txd      <= 2'b00;
            underrun <= 1'b0;
        end else begin
            state    <= state_nx;
            pre_cnt  <= pre_cnt_nx;
            fcs_cnt  <= fcs_cnt_nx;
            ifg_cnt  <= ifg_cnt_nx;
            len_cnt  <= len_cnt_nx;
            crc      <= crc_nx;
            txen     <= txen_nx;
            txd      <= txd_nx;
            underrun <= underrun_nx;
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: byte-level CRC-32 reference model, one task per scenario.
module tb_eth_tx_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_last;
    logic [1:0] in_data;
    int         sel;
    logic       iv0, iv1, rdy0, rdy1, txen0, txen1, busy0, busy1, und0, und1;
    logic [1:0] txd0, txd1;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);

    eth_tx_framer #(.MIN_DIBITS(0), .IFG_DIBITS(48)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy0), .txen(txen0), .txd(txd0), .busy(busy0), .underrun(und0));
    eth_tx_framer dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy1), .txen(txen1), .txd(txd1), .busy(busy1), .underrun(und1));

    logic       m_txen, m_rdy, m_busy, m_und;
    logic [1:0] m_txd;
    assign m_txen = (sel == 0) ? txen0 : txen1;
    assign m_txd  = (sel == 0) ? txd0  : txd1;
    assign m_rdy  = (sel == 0) ? rdy0  : rdy1;
    assign m_busy = (sel == 0) ? busy0 : busy1;
    assign m_und  = (sel == 0) ? und0  : und1;

    int checks = 0;
    int failures = 0;
    logic [1:0] pay[$];
    logic [1:0] exp_q[$];
    logic [1:0] cap[$];
    int hi_cnt, rises, gap_cur, gap_last, und_cnt, idle_bad;
    logic prev_txen;

    always @(negedge clk) begin
        if (m_txen) begin
            cap.push_back(m_txd);
            hi_cnt++;
            if (!prev_txen) begin
                rises++;
                if (rises > 1) gap_last = gap_cur;
            end
            gap_cur = 0;
        end else begin
            gap_cur++;
            if (m_txd !== 2'b00) idle_bad++;
        end
        if (m_und) und_cnt++;
        prev_txen = m_txen;
    end

    task automatic clear_mon();
        cap.delete();
        exp_q.delete();
        hi_cnt = 0; rises = 0; gap_cur = 0; gap_last = -1; und_cnt = 0; idle_bad = 0;
        prev_txen = m_txen;
    endtask

    task automatic gen_payload(input int nbytes);
        logic [7:0] b;
        pay.delete();
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom_range(0, 255));
            for (int j = 0; j < 4; j++) pay.push_back(b[2*j +: 2]);
        end
    endtask

    // Expected wire image: preamble, SFD, payload, zero pad, then reflected CRC-32 bytes LSB first.
    task automatic build_exp(input int min_d);
        logic [1:0]  body[$];
        logic [7:0]  b;
        logic [31:0] c;
        repeat (31) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        body = pay;
        while (body.size() < min_d) body.push_back(2'b00);
        foreach (body[i]) exp_q.push_back(body[i]);
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < body.size() / 4; k++) begin
            b = {body[4*k+3], body[4*k+2], body[4*k+1], body[4*k]};
            c = c ^ {24'h0, b};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int j = 0; j < 16; j++) exp_q.push_back(c[2*j +: 2]);
    endtask

    function automatic int stream_diff();
        int bad;
        if (cap.size() != exp_q.size()) return -1;
        bad = 0;
        foreach (cap[i]) if (cap[i] !== exp_q[i]) bad++;
        return bad;
    endfunction

    task automatic drive_frame(input int drop_at, output int first_hs);
        int i, n, guard;
        logic hs, dropped;
        i = 0; n = pay.size(); guard = 0; dropped = 1'b0; first_hs = -1;
        while (i < n && guard < 5000) begin
            if (i == drop_at && !dropped && m_rdy) begin
                in_valid = 1'b0;
                dropped  = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_data  = pay[i];
                in_last  = (i == n - 1);
            end
            hs = in_valid && m_rdy;
            @(posedge clk); #1;
            if (hs) begin
                if (first_hs < 0) first_hs = guard;
                i++;
            end
            guard++;
        end
        in_last = 1'b0;
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL drive_timeout accepted=%0d required=%0d", i, n);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (m_busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 2'b00; in_last = 1'b0; sel = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({txen0, txd0, rdy0, busy0, und0} !== 6'b0) begin
            failures++;
            $display("FAIL reset_dut0 got=%b exp=000000", {txen0, txd0, rdy0, busy0, und0});
        end
        checks++;
        if ({txen1, txd1, rdy1, busy1, und1} !== 6'b0) begin
            failures++;
            $display("FAIL reset_dut1 got=%b exp=000000", {txen1, txd1, rdy1, busy1, und1});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_check_value();
        string s;
        int fh, n, d;
        logic [7:0]  ch;
        logic [31:0] f;
        sel = 0;
        clear_mon();
        s = "123456789";
        pay.delete();
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            for (int j = 0; j < 4; j++) pay.push_back(ch[2*j +: 2]);
        end
        build_exp(0);
        drive_frame(-1, fh);
        in_valid = 1'b0;
        wait_idle(n);
        checks++;
        if (fh != 32) begin failures++; $display("FAIL cv_first_accept got=%0d exp=32", fh); end
        checks++;
        if (n != 64) begin failures++; $display("FAIL cv_last_to_idle got=%0d exp=64", n); end
        checks++;
        if (hi_cnt != 84) begin failures++; $display("FAIL cv_txen_cycles got=%0d exp=84", hi_cnt); end
        d = stream_diff();
        checks++;
        if (d != 0) begin failures++; $display("FAIL cv_stream diff=%0d exp=0", d); end
        f = 32'h0;
        if (cap.size() >= 16)
            for (int j = 0; j < 16; j++) f[2*j +: 2] = cap[cap.size() - 16 + j];
        checks++;
        if (f !== 32'hCBF4_3926) begin failures++; $display("FAIL cv_fcs got=%h exp=cbf43926", f); end
        checks++;
        if (rises != 1 || idle_bad != 0) begin
            failures++;
            $display("FAIL cv_txen_shape rises=%0d idle_bad=%0d exp=1,0", rises, idle_bad);
        end
    endtask

    task automatic test_padding();
        int fh, n, d;
        sel = 1;
        clear_mon();
        gen_payload(14);
        build_exp(240);
        drive_frame(-1, fh);
        in_valid = 1'b0;
        wait_idle(n);
        checks++;
        if (hi_cnt != 288) begin failures++; $display("FAIL pad_txen_cycles got=%0d exp=288", hi_cnt); end
        d = stream_diff();
        checks++;
        if (d != 0) begin failures++; $display("FAIL pad_stream diff=%0d exp=0", d); end
        checks++;
        if (fh != 32 || und_cnt != 0) begin
            failures++;
            $display("FAIL pad_misc first_accept=%0d underruns=%0d exp=32,0", fh, und_cnt);
        end
    endtask

    task automatic test_random_frames();
        int fh, n, d, nb, expl;
        sel = 1;
        for (int it = 0; it < 4; it++) begin
            clear_mon();
            nb = (it == 0) ? 60 : $urandom_range(1, 90);
            gen_payload(nb);
            build_exp(240);
            drive_frame(-1, fh);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            wait_idle(n);
            expl = 32 + ((4 * nb > 240) ? 4 * nb : 240) + 16;
            checks++;
            if (hi_cnt != expl) begin
                failures++;
                $display("FAIL rnd_txen_cycles bytes=%0d got=%0d exp=%0d", nb, hi_cnt, expl);
            end
            d = stream_diff();
            checks++;
            if (d != 0) begin failures++; $display("FAIL rnd_stream bytes=%0d diff=%0d exp=0", nb, d); end
        end
    endtask

    task automatic test_back_to_back();
        int fh, n, d;
        sel = 1;
        clear_mon();
        gen_payload($urandom_range(40, 80));
        build_exp(240);
        drive_frame(-1, fh);
        gen_payload($urandom_range(40, 80));
        build_exp(240);
        drive_frame(-1, fh);
        in_valid = 1'b0;
        wait_idle(n);
        checks++;
        if (rises != 2) begin failures++; $display("FAIL b2b_frames got=%0d exp=2", rises); end
        checks++;
        if (gap_last != 48) begin failures++; $display("FAIL b2b_gap got=%0d exp=48", gap_last); end
        d = stream_diff();
        checks++;
        if (d != 0) begin failures++; $display("FAIL b2b_stream diff=%0d exp=0", d); end
    endtask

    task automatic test_underrun();
        int fh, n, d;
        sel = 1;
        clear_mon();
        gen_payload(10);
        repeat (31) exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        for (int i = 0; i < 10; i++) exp_q.push_back(pay[i]);
        drive_frame(10, fh);
        in_valid = 1'b0;
        wait_idle(n);
        checks++;
        if (und_cnt != 1) begin failures++; $display("FAIL ur_pulses got=%0d exp=1", und_cnt); end
        checks++;
        if (hi_cnt != 42) begin failures++; $display("FAIL ur_txen_cycles got=%0d exp=42", hi_cnt); end
        d = stream_diff();
        checks++;
        if (d != 0) begin failures++; $display("FAIL ur_stream diff=%0d exp=0", d); end
        checks++;
        if (n != 48) begin failures++; $display("FAIL ur_ifg got=%0d exp=48", n); end
        checks++;
        if (idle_bad != 0) begin failures++; $display("FAIL ur_idle_txd got=%0d exp=0", idle_bad); end
    endtask

    task automatic test_reset_mid_fcs();
        int fh, n, d;
        sel = 1;
        clear_mon();
        gen_payload(64);
        drive_frame(-1, fh);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (m_txen !== 1'b1) begin failures++; $display("FAIL rst_pre_txen got=%b exp=1", m_txen); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({m_txen, m_txd, m_busy, m_rdy} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_fcs got=%b exp=00000", {m_txen, m_txd, m_busy, m_rdy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        gen_payload(16);
        build_exp(240);
        drive_frame(-1, fh);
        in_valid = 1'b0;
        wait_idle(n);
        d = stream_diff();
        checks++;
        if (d != 0) begin failures++; $display("FAIL rst_next_stream diff=%0d exp=0", d); end
        checks++;
        if (hi_cnt != 288) begin failures++; $display("FAIL rst_next_txen got=%0d exp=288", hi_cnt); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_check_value();
        test_padding();
        test_random_frames();
        test_back_to_back();
        test_underrun();
        test_reset_mid_fcs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
